draw_arbiter: RTL and testbench
===============================

DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of draw requesters, e.g. background, car, explosion, screens.
REQ-002 Parameter TIMEOUT, default 100000: maximum number of cycles one grant may be held.
REQ-003 Clock  input  1  system clock; all state updates on the rising edge.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 Enable1Frame  input  1  single-cycle frame tick.
REQ-006 req  input  NUM_REQ  per-requester draw request; held high until released.
REQ-007 done  input  NUM_REQ  per-requester last-pixel indication; valid only while granted.
REQ-008 reqX  input  9*NUM_REQ  packed pixel x coordinates; requester i occupies slice i.
REQ-009 reqY  input  8*NUM_REQ  packed pixel y coordinates.
REQ-010 reqColour  input  6*NUM_REQ  packed pixel colours.
REQ-011 reqPlot  input  NUM_REQ  per-requester pixel-write strobe.
REQ-012 grant  output  NUM_REQ  one-hot (or zero) registered grant.
REQ-013 busy  output  1  high while any grant is active.
REQ-014 xOut  output  9, yOut  output  8, colourOut  output  6  registered pixel to the VGA adapter.
REQ-015 plotOut  output  1  registered pixel write enable.
REQ-016 frameOverrun  output  1  one-cycle pulse: Enable1Frame arrived while busy.
REQ-017 timeoutErr  output  1  sticky flag; set on forced revoke, cleared only by reset.

Function
REQ-018 FSM states: IDLE, GRANT, RELEASE.
REQ-019 IDLE: if any req bit is high, select a winner by round-robin starting at pointer ptr; next cycle the state is GRANT with grant set one-hot to the winner.
REQ-020 IDLE with req all zero: remain in IDLE; grant is 0.
REQ-021 GRANT, winner g: each cycle register xOut/yOut/colourOut from slice g and set plotOut = reqPlot[g]; latency from requester strobe to plotOut is 1 cycle.
REQ-022 GRANT: when done[g]=1, or req[g] drops, move next cycle to RELEASE with grant=0 and ptr=(g+1) mod NUM_REQ.
REQ-023 The done cycle's pixel shall still be output.
REQ-024 GRANT holds a cycle counter, cleared on entry; when it reaches TIMEOUT-1 without done: move to RELEASE, set timeoutErr, and advance ptr as in REQ-022.
REQ-025 done and timeout in the same cycle: done wins; timeoutErr is not set.
REQ-026 RELEASE: exactly one dead cycle with plotOut=0 and grant=0, then IDLE.
REQ-027 The same requester therefore cannot be regranted sooner than 2 cycles after release.
REQ-028 Outside GRANT, plotOut=0 and xOut/yOut/colourOut hold their last values.
REQ-029 busy = (state==GRANT), registered with grant.
REQ-030 frameOverrun pulses for 1 cycle when Enable1Frame=1 and state==GRANT; the grant is unaffected.
REQ-031 done or reqPlot from non-granted requesters shall be ignored.
REQ-032 ptr wraps from NUM_REQ-1 to 0.
REQ-033 The round-robin search order is ptr, ptr+1, … wrapping.

Reset
REQ-034 Resetn low: immediately, regardless of clock, state=IDLE, grant=0, busy=0, plotOut=0, xOut=0, yOut=0, colourOut=0, frameOverrun=0, timeoutErr=0, ptr=0, timeout counter=0.
REQ-035 Reset asserted mid-burst aborts the burst with no RELEASE cycle.
REQ-036 After Resetn deasserts, arbitration restarts from requester 0.

Structure
REQ-037 Shared package draw_arb_pkg holds the state enum, coordinate and colour widths (9/8/6) and the default NUM_REQ and TIMEOUT values.
REQ-038 One sub-module, rr_pick: combinational round-robin one-hot picker taking (req, ptr) and returning a winner index and valid.
REQ-039 draw_arbiter shall instantiate rr_pick once.

Verification
REQ-040 Scenario: req=0100, ptr=0 -> grant=0100 one cycle later; reqX slice2=37 with reqPlot[2]=1 -> xOut=37, plotOut=1 on the next cycle.
REQ-041 Scenario: req=1111 held with done pulsed after each grant -> grant order 0001, 0010, 0100, 1000, 0001; each pair separated by one RELEASE cycle.
REQ-042 Scenario: TIMEOUT=8, granted requester never asserts done -> grant drops after 8 cycles, timeoutErr=1 and stays 1 until reset.
REQ-043 Scenario: done and timeout coincide (done on cycle 8, TIMEOUT=8) -> release with timeoutErr=0.
REQ-044 Scenario: Enable1Frame pulse during GRANT -> frameOverrun=1 for exactly 1 cycle; the same pulse in IDLE -> 0.
REQ-045 Scenario: Resetn low mid-burst with no clock edge -> plotOut=0, grant=0 immediately; after release, req=1010 -> grant=0010.

Source files
------------

// File: rtl/draw_arb_pkg.sv
// Shared types and constants for the draw arbiter and its helpers.
package draw_arb_pkg;

  localparam int unsigned XWidth      = 9;
  localparam int unsigned YWidth      = 8;
  localparam int unsigned ColourWidth = 6;

  localparam int unsigned DefNumReq  = 4;
  localparam int unsigned DefTimeout = 100000;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRelease
  } arbState_e;

  // Bits needed to index n items; never less than one.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_arbiter_if.sv
// Requester-side and VGA-side signals of the draw arbiter.
interface draw_arbiter_if #(
  parameter int unsigned NUM_REQ = draw_arb_pkg::DefNumReq
);
  import draw_arb_pkg::*;

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             done;
  logic [XWidth*NUM_REQ-1:0]      reqX;
  logic [YWidth*NUM_REQ-1:0]      reqY;
  logic [ColourWidth*NUM_REQ-1:0] reqColour;
  logic [NUM_REQ-1:0]             reqPlot;

  logic [NUM_REQ-1:0]     grant;
  logic                   busy;
  logic [XWidth-1:0]      xOut;
  logic [YWidth-1:0]      yOut;
  logic [ColourWidth-1:0] colourOut;
  logic                   plotOut;
  logic                   frameOverrun;
  logic                   timeoutErr;

  // Requesters (and the VGA consumer) side.
  modport master (
    output req, done, reqX, reqY, reqColour, reqPlot,
    input  grant, busy, xOut, yOut, colourOut, plotOut, frameOverrun, timeoutErr
  );

  // Arbiter side.
  modport slave (
    input  req, done, reqX, reqY, reqColour, reqPlot,
    output grant, busy, xOut, yOut, colourOut, plotOut, frameOverrun, timeoutErr
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);

  int unsigned      idx;
  logic [PTR_W-1:0] idxN;

  // Scan from farthest to nearest so the nearest set request is assigned last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    idxN   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = 32'(ptr) + 32'(k);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idxN = PTR_W'(idx);
      if (req[idxN]) begin
        valid  = 1'b1;
        winner = idxN;
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin arbiter multiplexing several pixel drawers onto one VGA write port.
module draw_arbiter
  import draw_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input logic           Clock,
  input logic           Resetn,
  input logic           Enable1Frame,
  draw_arbiter_if.slave bus
);

  localparam int unsigned PtrW = idxWidth(NUM_REQ);
  localparam int unsigned CntW = idxWidth(TIMEOUT);

  arbState_e              stateQ, stateD;
  logic [NUM_REQ-1:0]     grantQ, grantD;
  logic [PtrW-1:0]        ownerQ, ownerD;
  logic [PtrW-1:0]        ptrQ, ptrD;
  logic [CntW-1:0]        cntQ, cntD;
  logic [XWidth-1:0]      xQ, xD;
  logic [YWidth-1:0]      yQ, yD;
  logic [ColourWidth-1:0] colourQ, colourD;
  logic                   plotQ, plotD;
  logic                   overrunQ, overrunD;
  logic                   errQ, errD;

  logic [PtrW-1:0]        pickIdx;
  logic                   pickValid;
  logic [PtrW-1:0]        ptrAfterOwner;

  logic                   reqSel, doneSel, plotSel;
  logic [XWidth-1:0]      xSel;
  logic [YWidth-1:0]      ySel;
  logic [ColourWidth-1:0] colourSel;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) uPick (
    .req    (bus.req),
    .ptr    (ptrQ),
    .winner (pickIdx),
    .valid  (pickValid)
  );

  // Route the current owner's signals; everyone else is ignored.
  always_comb begin
    reqSel    = 1'b0;
    doneSel   = 1'b0;
    plotSel   = 1'b0;
    xSel      = '0;
    ySel      = '0;
    colourSel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ownerQ == PtrW'(i)) begin
        reqSel    = bus.req[i];
        doneSel   = bus.done[i];
        plotSel   = bus.reqPlot[i];
        xSel      = bus.reqX[i*XWidth +: XWidth];
        ySel      = bus.reqY[i*YWidth +: YWidth];
        colourSel = bus.reqColour[i*ColourWidth +: ColourWidth];
      end
    end
  end

  assign ptrAfterOwner = (ownerQ == PtrW'(NUM_REQ - 1)) ? '0 : ownerQ + PtrW'(1);

  // Next-state: arbitration, pixel pass-through, timeout and overrun detection.
  always_comb begin
    stateD   = stateQ;
    grantD   = grantQ;
    ownerD   = ownerQ;
    ptrD     = ptrQ;
    cntD     = '0;
    xD       = xQ;
    yD       = yQ;
    colourD  = colourQ;
    plotD    = 1'b0;
    errD     = errQ;
    overrunD = Enable1Frame && (stateQ == StGrant);

    unique case (stateQ)
      StIdle: begin
        grantD = '0;
        if (pickValid) begin
          stateD = StGrant;
          ownerD = pickIdx;
          grantD = NUM_REQ'(1) << pickIdx;
        end
      end

      StGrant: begin
        // Every granted cycle's pixel goes out, including the final one.
        xD      = xSel;
        yD      = ySel;
        colourD = colourSel;
        plotD   = plotSel;
        cntD    = cntQ + CntW'(1);
        // A voluntary finish takes priority over a coinciding timeout.
        if (doneSel || !reqSel) begin
          stateD = StRelease;
          grantD = '0;
          ptrD   = ptrAfterOwner;
        end else if (cntQ == CntW'(TIMEOUT - 1)) begin
          stateD = StRelease;
          grantD = '0;
          ptrD   = ptrAfterOwner;
          errD   = 1'b1;
        end
      end

      StRelease: begin
        stateD = StIdle;
        grantD = '0;
      end

      default: begin
        stateD = StIdle;
        grantD = '0;
      end
    endcase
  end

  // State register; reset aborts any burst immediately.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      stateQ   <= StIdle;
      grantQ   <= '0;
      ownerQ   <= '0;
      ptrQ     <= '0;
      cntQ     <= '0;
      xQ       <= '0;
      yQ       <= '0;
      colourQ  <= '0;
      plotQ    <= 1'b0;
      overrunQ <= 1'b0;
      errQ     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      grantQ   <= grantD;
      ownerQ   <= ownerD;
      ptrQ     <= ptrD;
      cntQ     <= cntD;
      xQ       <= xD;
      yQ       <= yD;
      colourQ  <= colourD;
      plotQ    <= plotD;
      overrunQ <= overrunD;
      errQ     <= errD;
    end
  end

  assign bus.grant        = grantQ;
  assign bus.busy         = (stateQ == StGrant);
  assign bus.xOut         = xQ;
  assign bus.yOut         = yQ;
  assign bus.colourOut    = colourQ;
  assign bus.plotOut      = plotQ;
  assign bus.frameOverrun = overrunQ;
  assign bus.timeoutErr   = errQ;

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: behavioural model plus directed scenarios.
module tb_draw_arbiter;
  import draw_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;

  logic Clock        = 1'b0;
  logic Resetn       = 1'b0;
  logic Enable1Frame = 1'b0;

  draw_arbiter_if #(.NUM_REQ(N)) bus ();

  draw_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .Enable1Frame (Enable1Frame),
    .bus          (bus)
  );

  always #5 Clock = ~Clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit autoPix     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge; optionally churn pixel data.
  task automatic step();
    @(negedge Clock);
    cyc++;
    if (autoPix) begin
      for (int i = 0; i < N; i++) begin
        bus.reqX[i*XWidth +: XWidth]                = 9'((cyc * 13 + i * 101) % 512);
        bus.reqY[i*YWidth +: YWidth]                = 8'((cyc * 7 + i * 61) % 256);
        bus.reqColour[i*ColourWidth +: ColourWidth] = 6'((cyc * 5 + i * 17) % 64);
      end
      bus.reqPlot = 4'(cyc * 5);
    end
  endtask

  task automatic waitGrant();
    int w = 0;
    while (bus.grant == '0 && w < 10) begin
      step();
      w++;
    end
    if (w == 10) chk("grant wait budget", 32'(w), 32'(0));
  endtask

  task automatic doReset();
    #2 Resetn = 1'b0;
    step();
    Resetn = 1'b1;
  endtask

  // ---------------- behavioural model ----------------
  int          mOwner, mHeld, mPtr;
  bit          mDead, mErr, mPlot, mOvr;
  logic [8:0]  mX;
  logic [7:0]  mY;
  logic [5:0]  mC;

  logic [N-1:0]             sReq, sDone, sPlot;
  logic [XWidth*N-1:0]      sX;
  logic [YWidth*N-1:0]      sY;
  logic [ColourWidth*N-1:0] sC;
  bit                       sRst, sEn;

  task automatic modelStep();
    if (!sRst) begin
      mOwner = -1; mHeld = 0; mPtr = 0; mDead = 0; mErr = 0;
      mPlot = 0; mOvr = 0; mX = '0; mY = '0; mC = '0;
      return;
    end
    mOvr  = sEn && (mOwner >= 0);
    mPlot = 1'b0;
    if (mOwner >= 0) begin
      mPlot = sPlot[mOwner];
      mX    = sX[mOwner*XWidth +: XWidth];
      mY    = sY[mOwner*YWidth +: YWidth];
      mC    = sC[mOwner*ColourWidth +: ColourWidth];
      if (sDone[mOwner] || !sReq[mOwner] || mHeld == TO - 1) begin
        if (!(sDone[mOwner] || !sReq[mOwner])) mErr = 1'b1;
        mPtr   = (mOwner + 1) % N;
        mOwner = -1;
        mDead  = 1'b1;
      end else begin
        mHeld++;
      end
    end else if (mDead) begin
      mDead = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (mOwner < 0 && sReq[(mPtr + k) % N]) begin
          mOwner = (mPtr + k) % N;
          mHeld  = 0;
        end
      end
    end
  endtask

  // Compare DUT against the model just after every rising edge.
  initial begin : compare
    forever begin
      @(posedge Clock);
      sRst = Resetn; sEn = Enable1Frame;
      sReq = bus.req; sDone = bus.done; sPlot = bus.reqPlot;
      sX = bus.reqX; sY = bus.reqY; sC = bus.reqColour;
      #1;
      modelStep();
      chk("model grant", 32'(bus.grant), (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0);
      chk("model busy", 32'(bus.busy), 32'(mOwner >= 0));
      chk("model plotOut", 32'(bus.plotOut), 32'(mPlot));
      chk("model xOut", 32'(bus.xOut), 32'(mX));
      chk("model yOut", 32'(bus.yOut), 32'(mY));
      chk("model colourOut", 32'(bus.colourOut), 32'(mC));
      chk("model frameOverrun", 32'(bus.frameOverrun), 32'(mOvr));
      chk("model timeoutErr", 32'(bus.timeoutErr), 32'(mErr));
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int count;

  initial begin : stim
    bus.req = '0; bus.done = '0; bus.reqPlot = '0;
    bus.reqX = '0; bus.reqY = '0; bus.reqColour = '0;
    #1;
    chk("reset grant", 32'(bus.grant), 0);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset plotOut", 32'(bus.plotOut), 0);
    chk("reset xOut", 32'(bus.xOut), 0);
    chk("reset timeoutErr", 32'(bus.timeoutErr), 0);
    step(); step();
    Resetn = 1'b1;

    // Single requester, pixel pass-through, foreign done/plot ignored.
    bus.reqX[2*XWidth +: XWidth] = 9'd37;
    bus.reqPlot = 4'b0100;
    bus.req     = 4'b0100;
    step();
    chk("s040 grant", 32'(bus.grant), 32'b0100);
    chk("s040 plot before data", 32'(bus.plotOut), 0);
    bus.done    = 4'b0001;
    bus.reqPlot = 4'b0101;
    step();
    chk("s040 xOut", 32'(bus.xOut), 37);
    chk("s040 plotOut", 32'(bus.plotOut), 1);
    chk("s040 foreign done ignored", 32'(bus.grant), 32'b0100);
    bus.reqX[2*XWidth +: XWidth] = 9'd38;
    bus.done = 4'b0100;
    step();
    chk("s040 done pixel x", 32'(bus.xOut), 38);
    chk("s040 done pixel plot", 32'(bus.plotOut), 1);
    chk("s040 release grant", 32'(bus.grant), 0);
    bus.done = '0; bus.req = '0; bus.reqPlot = '0;
    step();
    chk("s040 hold xOut", 32'(bus.xOut), 38);
    chk("s040 idle plot", 32'(bus.plotOut), 0);

    // Round-robin rotation with all requesters active.
    doReset();
    autoPix = 1'b1;
    bus.req = 4'b1111;
    foreach (order[k]) begin
      waitGrant();
      chk("s041 rr order", 32'(bus.grant), 32'(order[k]));
      step();
      bus.done = bus.grant;
      step();
      bus.done = '0;
      chk("s041 release", 32'(bus.grant), 0);
    end
    bus.req = '0;
    step(); step();

    // Timeout revoke, sticky error.
    doReset();
    bus.req = 4'b0001;
    waitGrant();
    count = 0;
    while (bus.grant == 4'b0001 && count < 20) begin
      count++;
      step();
    end
    bus.req = '0;
    chk("s042 grant cycles", 32'(count), 8);
    chk("s042 timeoutErr set", 32'(bus.timeoutErr), 1);
    step(); step(); step();
    chk("s042 timeoutErr sticky", 32'(bus.timeoutErr), 1);

    // done coinciding with the last allowed cycle.
    doReset();
    chk("s043 err cleared by reset", 32'(bus.timeoutErr), 0);
    bus.req = 4'b0001;
    waitGrant();
    for (int c = 1; c < 8; c++) step();
    chk("s043 still granted", 32'(bus.grant), 32'b0001);
    bus.done = 4'b0001;
    step();
    bus.done = '0; bus.req = '0;
    chk("s043 released", 32'(bus.grant), 0);
    chk("s043 no timeoutErr", 32'(bus.timeoutErr), 0);
    step();

    // Frame tick during grant and during idle.
    bus.req = 4'b0010;
    waitGrant();
    Enable1Frame = 1'b1;
    step();
    Enable1Frame = 1'b0;
    chk("s044 overrun pulse", 32'(bus.frameOverrun), 1);
    chk("s044 grant kept", 32'(bus.grant), 32'b0010);
    step();
    chk("s044 overrun one cycle", 32'(bus.frameOverrun), 0);
    bus.req = '0;
    step(); step(); step();
    Enable1Frame = 1'b1;
    step();
    Enable1Frame = 1'b0;
    chk("s044 idle no overrun", 32'(bus.frameOverrun), 0);

    // Asynchronous reset mid-burst.
    autoPix = 1'b0;
    bus.reqX[2*XWidth +: XWidth] = 9'd99;
    bus.reqPlot = 4'b0100;
    bus.req = 4'b0100;
    waitGrant();
    step();
    chk("s045 plotting", 32'(bus.plotOut), 1);
    #2 Resetn = 1'b0;
    #1;
    chk("s045 async plotOut", 32'(bus.plotOut), 0);
    chk("s045 async grant", 32'(bus.grant), 0);
    chk("s045 async xOut", 32'(bus.xOut), 0);
    step();
    Resetn  = 1'b1;
    bus.req = 4'b1010;
    step();
    chk("s045 restart from 0", 32'(bus.grant), 32'b0010);
    bus.req = '0;
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
